// File: rtl/dmux4_seq_pkg.sv
// dmux4_seq_pkg
// Shared types and constants for the dmux4_seq sequencer and its hold timer.
//   state_t     : sequencer FSM states (IDLE, DRIVE, GAP)
//   CH_W        : channel index width
//   NUM_CH      : number of demux channels
//   STAT_W      : per-channel delivered-ones counter width
//   TMR_W       : hold timer width (HOLD_CYCLES up to 255)
//   chan_onehot : channel index to one-hot chan_done vector
package dmux4_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int CH_W   = 2;
  localparam int NUM_CH = 4;
  localparam int STAT_W = 8;
  localparam int TMR_W  = 8;

  function automatic logic [NUM_CH-1:0] chan_onehot(input logic [CH_W-1:0] ch);
    return NUM_CH'(1) << ch;
  endfunction

endpackage

// File: rtl/dmux4_hold_timer.sv
// dmux4_hold_timer
// Loadable down-counter that times the DRIVE dwell of the sequencer.
// Ports:
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset, clears the count
//   load     : load load_val (has priority over dec)
//   load_val : value loaded into the counter
//   dec      : decrement by one; the count stops at zero
//   zero     : high while the count is zero
module dmux4_hold_timer
  import dmux4_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - TMR_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/dmux4_seq.sv
// dmux4_seq
// Upstream sequencer for a 1-to-4 demux. Accepts one data bit per valid/ready
// handshake, picks a channel (round-robin or addressed), drives s1/s0/dout for
// HOLD_CYCLES cycles, then inserts a one-cycle gap with dout low so the selects
// only ever change while dout is low.
// Optional feature: define DMUX4_SEQ_STATS_EN to build the per-channel
// saturating counters of delivered '1' bits; otherwise stat_cnt0..3 read 0.
// Parameters:
//   HOLD_CYCLES : cycles the bit is driven onto the demux (1..255)
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : upstream handshake; in_data is the bit to route
//   mode, addr          : 0 = round-robin, 1 = use addr; sampled at accept
//   s0, s1, dout        : demux select lines and demux data input
//   busy                : high in DRIVE and GAP
//   chan_done           : one-cycle pulse, bit n = delivery to channel n done
//   stat_cnt0..3        : per-channel count of delivered '1' bits
module dmux4_seq
  import dmux4_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_data,
  output logic              in_ready,
  input  logic              mode,
  input  logic [CH_W-1:0]   addr,
  output logic              s0,
  output logic              s1,
  output logic              dout,
  output logic              busy,
  output logic [NUM_CH-1:0] chan_done,
  output logic [STAT_W-1:0] stat_cnt0,
  output logic [STAT_W-1:0] stat_cnt1,
  output logic [STAT_W-1:0] stat_cnt2,
  output logic [STAT_W-1:0] stat_cnt3
);

  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);

  state_t            state, state_nxt;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   sel_p0, sel_nxt;
  logic              bit_p0;
  logic              mode_p0;
  logic              dout_nxt;
  logic [NUM_CH-1:0] done_nxt;
  logic              accept;
  logic              tmr_load, tmr_dec, tmr_zero;

  // in_ready depends only on the state register, never on in_valid.
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign {s1, s0} = sel_p0;

  dmux4_hold_timer u_hold_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (HOLD_LOAD),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_p0;
    dout_nxt  = 1'b0;
    done_nxt  = '0;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = DRIVE;
          sel_nxt   = mode ? addr : rr_ptr;
          dout_nxt  = in_data;
          tmr_load  = 1'b1;
        end
      end
      DRIVE: begin
        tmr_dec = 1'b1;
        // Counter at zero means the current cycle is the last dwell cycle.
        if (tmr_zero) begin
          state_nxt = GAP;
          done_nxt  = chan_onehot(sel_p0);
        end else begin
          dout_nxt = bit_p0;
        end
      end
      GAP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sel_p0    <= '0;
      dout      <= 1'b0;
      chan_done <= '0;
      rr_ptr    <= '0;
      mode_p0   <= 1'b0;
    end else begin
      state     <= state_nxt;
      sel_p0    <= sel_nxt;
      dout      <= dout_nxt;
      chan_done <= done_nxt;
      if (accept) begin
        mode_p0 <= mode;
      end
      if ((state == GAP) && !mode_p0) begin
        rr_ptr <= rr_ptr + CH_W'(1);
      end
    end
  end

  // Latched data bit; meaningless outside DRIVE/GAP so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      bit_p0 <= in_data;
    end
  end

`ifdef DMUX4_SEQ_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

  logic [STAT_W-1:0] stat_q [NUM_CH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < NUM_CH; n++) begin
        stat_q[n] <= '0;
      end
    end else if ((state == GAP) && bit_p0) begin
      stat_q[sel_p0] <= sat_inc(stat_q[sel_p0]);
    end
  end

  assign stat_cnt0 = stat_q[0];
  assign stat_cnt1 = stat_q[1];
  assign stat_cnt2 = stat_q[2];
  assign stat_cnt3 = stat_q[3];
`else
  assign stat_cnt0 = '0;
  assign stat_cnt1 = '0;
  assign stat_cnt2 = '0;
  assign stat_cnt3 = '0;
`endif

endmodule

// File: tb/tb_dmux4_seq.sv
// tb_dmux4_seq
// Scoreboard bench for dmux4_seq. The driver pushes the expected delivery
// (channel, bit, completion cycle) at each accept; a monitor pops and compares
// on every chan_done pulse. A second instance with HOLD_CYCLES=1 runs with
// in_valid tied high to check the 3-cycle accept period.
module tb_dmux4_seq;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_data = 1'b0;
  logic       mode = 1'b0;
  logic [1:0] addr = 2'd0;
  logic       in_ready, s0, s1, dout, busy;
  logic [3:0] chan_done;
  logic [7:0] st0, st1, st2, st3;

  logic       h1_ready, h1_s0, h1_s1, h1_dout, h1_busy;
  logic [3:0] h1_done;
  logic [7:0] h1_st0, h1_st1, h1_st2, h1_st3;

  dmux4_seq #(.HOLD_CYCLES(H)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mode(mode), .addr(addr), .s0(s0), .s1(s1),
    .dout(dout), .busy(busy), .chan_done(chan_done),
    .stat_cnt0(st0), .stat_cnt1(st1), .stat_cnt2(st2), .stat_cnt3(st3)
  );

  dmux4_seq #(.HOLD_CYCLES(1)) dut_h1 (
    .clk(clk), .reset(reset), .in_valid(1'b1), .in_data(1'b1),
    .in_ready(h1_ready), .mode(1'b0), .addr(2'd0), .s0(h1_s0), .s1(h1_s1),
    .dout(h1_dout), .busy(h1_busy), .chan_done(h1_done),
    .stat_cnt0(h1_st0), .stat_cnt1(h1_st1), .stat_cnt2(h1_st2), .stat_cnt3(h1_st3)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int chan;
    bit b;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  int   rr_model = 0;
  int   stat_model[4] = '{0, 0, 0, 0};

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples after the clock edge has settled.
  exp_t mon_e;
  int   hi_cnt = 0;
  logic prev_dout = 1'b0;
  int   prev_sel = 0;
  int   h1_last = -1;
  int   h1_exp = 0;

  always @(posedge clk) begin
    #2;
    if (reset) begin
      hi_cnt  = 0;
      h1_last = -1;
      h1_exp  = 0;
    end else begin
      if (prev_dout) check("bbm_sel_stable", {s1, s0}, prev_sel);
      if (dout) hi_cnt++;
      if (chan_done != 4'd0) begin
        if (sbq.size() == 0) begin
          check("unexpected_done", chan_done, 0);
        end else begin
          mon_e = sbq.pop_front();
          check("done_chan", chan_done, 1 << mon_e.chan);
          check("done_cycle", cyc, mon_e.cyc);
          check("dout_width", hi_cnt, mon_e.b ? H : 0);
          check("sel_in_gap", {s1, s0}, mon_e.chan);
          check("dout_in_gap", dout, 0);
          check("busy_in_gap", busy, 1);
          if (mon_e.b && stat_model[mon_e.chan] < 255) stat_model[mon_e.chan]++;
        end
        hi_cnt = 0;
      end
      if (h1_done != 4'd0) begin
        check("h1_chan", h1_done, 1 << h1_exp);
        if (h1_last >= 0) check("h1_period", cyc - h1_last, 3);
        h1_last = cyc;
        h1_exp  = (h1_exp + 1) % 4;
      end
    end
    prev_dout = dout;
    prev_sel  = {s1, s0};
  end

  // Called at a negedge; returns at the negedge after the accept.
  task automatic send(input bit m, input bit [1:0] a, input bit d, input bit keep);
    int guard = 0;
    int ch;
    in_valid = 1'b1;
    mode     = m;
    addr     = a;
    in_data  = d;
    while (!in_ready) begin
      @(negedge clk);
      guard++;
      if (guard > 600) begin
        check("ready_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    ch = m ? int'(a) : rr_model;
    if (!m) rr_model = (rr_model + 1) % 4;
    sbq.push_back('{ch, d, cyc + H + 1});
    @(negedge clk);
    if (!keep) in_valid = 1'b0;
    // Scramble sampled-at-accept inputs; they must have no effect now.
    mode    = 1'($urandom);
    addr    = 2'($urandom);
    in_data = 1'($urandom);
  endtask

  task automatic clear_model();
    sbq.delete();
    rr_model = 0;
    for (int i = 0; i < 4; i++) stat_model[i] = 0;
  endtask

  task automatic do_reset(input int n);
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
    clear_model();
  endtask

  task automatic check_stats(input string tag);
`ifdef DMUX4_SEQ_STATS_EN
    check({tag, "_stat0"}, st0, stat_model[0]);
    check({tag, "_stat1"}, st1, stat_model[1]);
    check({tag, "_stat2"}, st2, stat_model[2]);
    check({tag, "_stat3"}, st3, stat_model[3]);
`else
    check({tag, "_stat0"}, st0, 0);
    check({tag, "_stat1"}, st1, 0);
    check({tag, "_stat2"}, st2, 0);
    check({tag, "_stat3"}, st3, 0);
`endif
  endtask

  initial begin
    @(negedge clk);
    do_reset(3);

    // Reset state
    check("rst_ready", in_ready, 1);
    check("rst_dout", dout, 0);
    check("rst_sel", {s1, s0}, 0);
    check("rst_busy", busy, 0);
    check("rst_done", chan_done, 0);
    check_stats("rst");

    // Four round-robin ones back-to-back
    for (int i = 0; i < 4; i++) send(1'b0, 2'd0, 1'b1, 1'b1);
    in_valid = 1'b0;
    repeat (H + 4) @(negedge clk);
    check("rr_drained", sbq.size(), 0);

    // Addressed to channel 2, then a round-robin bit still goes to channel 0
    send(1'b1, 2'd2, 1'b1, 1'b0);
    send(1'b0, 2'd0, 1'b1, 1'b0);
    repeat (H + 4) @(negedge clk);
    check("addr_drained", sbq.size(), 0);

    // Reset in the second DRIVE cycle
    send(1'b0, 2'd0, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    check("midrst_dout", dout, 0);
    check("midrst_sel", {s1, s0}, 0);
    check("midrst_ready", in_ready, 1);
    check("midrst_done", chan_done, 0);
    check("midrst_busy", busy, 0);
    send(1'b0, 2'd0, 1'b1, 1'b0);
    repeat (H + 4) @(negedge clk);
    check("midrst_drained", sbq.size(), 0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      bit k;
      k = 1'($urandom);
      send(1'($urandom), 2'($urandom), 1'($urandom), k);
      if (!k) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (H + 4) @(negedge clk);
    check("rand_drained", sbq.size(), 0);
    check_stats("rand");

    // Saturation: 300 ones and 5 zeros to channel 1
    do_reset(2);
    for (int i = 0; i < 300; i++) send(1'b1, 2'd1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) send(1'b1, 2'd1, 1'b0, 1'b1);
    in_valid = 1'b0;
    repeat (H + 4) @(negedge clk);
    check("sat_drained", sbq.size(), 0);
    check_stats("sat");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
